// File: rtl/lut_config_loader.sv
// Bitstream loader for a chained two-LUT block: collects BEATS words into a
// shift register, then pulses cfg_en for one cycle while cfg_data holds the image.
module lut_config_loader #(
  parameter int INPUTS   = 4,
  parameter int MEM_SIZE = 2 ** INPUTS,
  parameter int WORD_W   = 8
) (
  input  logic                  config_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [WORD_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  cfg_en,
  output logic [2*MEM_SIZE-1:0] cfg_data,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  localparam int CFG_W = 2 * MEM_SIZE;
  localparam int BEATS = CFG_W / WORD_W;
  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CFG_W-1:0] shift_r;

  assign cfg_data = shift_r;

  // Load sequencer; every status output is a register updated with the state.
  always_ff @(posedge config_clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      shift_r  <= '0;
      in_ready <= 1'b0;
      cfg_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      cfg_en  <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state_r)
        IDLE: begin
          // start beats abort here: abort only matters once a load is running
          if (start) begin
            state_r  <= LOAD;
            cnt_r    <= '0;
            shift_r  <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            aborted  <= 1'b1;
          end else if (in_valid && in_ready) begin
            shift_r <= CFG_W'({shift_r, in_data});
            cnt_r   <= cnt_r + CNT_W'(1);
            if (cnt_r == LAST_BEAT) begin
              state_r  <= COMMIT;
              in_ready <= 1'b0;
              cfg_en   <= 1'b1;
            end
          end
        end
        COMMIT: begin
          state_r <= DONE;
          done    <= 1'b1;
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_config_loader.sv
// Self-checking bench for lut_config_loader (INPUTS=4, WORD_W=8, four beats).
module tb_lut_config_loader;

  logic        config_clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        cfg_en;
  logic [31:0] cfg_data;
  logic        busy;
  logic        done;
  logic        aborted;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cfg    = 0;
  int n_done   = 0;
  logic prev_cfg_en = 1'b0;
  logic [31:0] exp_q [$];

  lut_config_loader #(.INPUTS(4), .WORD_W(8)) dut (
    .config_clk(config_clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cfg_en(cfg_en), .cfg_data(cfg_data), .busy(busy), .done(done),
    .aborted(aborted)
  );

  always #5 config_clk = ~config_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every cfg_en pulse consumes one expected image; done must trail cfg_en.
  always @(negedge config_clk) begin
    if (!rst) begin
      if (cfg_en) begin
        n_cfg++;
        if (exp_q.size() == 0) begin
          check("unexpected_cfg_en", 32'd1, 32'd0);
        end else begin
          check("cfg_data_at_commit", cfg_data, exp_q.pop_front());
        end
      end
      check("done_follows_cfg_en", {31'd0, done}, {31'd0, prev_cfg_en});
      if (done) n_done++;
      prev_cfg_en = cfg_en;
    end else begin
      prev_cfg_en = 1'b0;
    end
  end

  typedef struct packed {
    logic [31:0] data;       // first beat is the MSB byte
    logic [5:0]  gaps;       // idle cycles after beats 0,1,2 (2 bits each)
    logic [2:0]  restart;    // beat index after which start is re-pulsed, 7 = never
    logic        in_commit;  // pulse start while in COMMIT
    logic        with_abort; // raise abort together with the initial start
  } vec_t;

  task automatic do_load(input vec_t v);
    int c0;
    int d0;
    c0 = n_cfg;
    d0 = n_done;
    @(negedge config_clk);
    start = 1'b1;
    abort = v.with_abort;
    @(negedge config_clk);
    start = 1'b0;
    abort = 1'b0;
    check("load_busy", {31'd0, busy}, 32'd1);
    check("load_in_ready", {31'd0, in_ready}, 32'd1);
    check("load_aborted_low", {31'd0, aborted}, 32'd0);
    check("load_shift_cleared", cfg_data, 32'd0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v.data[31-8*i -: 8];
      if (i == 3) exp_q.push_back(v.data);
      @(negedge config_clk);
      in_valid = 1'b0;
      in_data  = 8'hEE;
      if (i < 3) begin
        for (int g = 0; g < int'(v.gaps[2*i +: 2]); g++) begin
          check("gap_in_ready", {31'd0, in_ready}, 32'd1);
          @(negedge config_clk);
        end
        if (int'(v.restart) == i) begin
          start = 1'b1;
          @(negedge config_clk);
          start = 1'b0;
          check("restart_in_ready", {31'd0, in_ready}, 32'd1);
        end
      end
    end
    check("commit_cfg_en", {31'd0, cfg_en}, 32'd1);
    check("commit_in_ready", {31'd0, in_ready}, 32'd0);
    check("commit_busy", {31'd0, busy}, 32'd1);
    if (v.in_commit) start = 1'b1;
    @(negedge config_clk);
    start = 1'b0;
    check("done_pulse", {31'd0, done}, 32'd1);
    check("cfg_en_single", {31'd0, cfg_en}, 32'd0);
    @(negedge config_clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("cfg_data_held", cfg_data, v.data);
    @(negedge config_clk);
    check("no_relaunch", {31'd0, busy}, 32'd0);
    check("one_cfg_en", n_cfg, c0 + 1);
    check("one_done", n_done, d0 + 1);
  endtask

  vec_t vecs [5];
  vec_t v;

  initial begin
    vecs[0] = '{data: 32'hA53CFF01, gaps: 6'b00_00_00, restart: 3'd7, in_commit: 1'b0, with_abort: 1'b0};
    vecs[1] = '{data: 32'hA53CFF01, gaps: 6'b11_10_01, restart: 3'd7, in_commit: 1'b0, with_abort: 1'b0};
    vecs[2] = '{data: 32'hA53CFF01, gaps: 6'b10_00_11, restart: 3'd7, in_commit: 1'b0, with_abort: 1'b0};
    vecs[3] = '{data: 32'h12345678, gaps: 6'b00_01_00, restart: 3'd0, in_commit: 1'b1, with_abort: 1'b0};
    vecs[4] = '{data: 32'hC0FFEE42, gaps: 6'b00_00_00, restart: 3'd7, in_commit: 1'b0, with_abort: 1'b1};

    // reset state
    @(negedge config_clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_cfg_en", {31'd0, cfg_en}, 32'd0);
    check("rst_cfg_data", cfg_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_aborted", {31'd0, aborted}, 32'd0);
    rst = 1'b0;
    @(negedge config_clk);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    for (int k = 0; k < 5; k++) do_load(vecs[k]);

    // abort with a same-cycle beat, then a clean reload
    @(negedge config_clk);
    start = 1'b1;
    @(negedge config_clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h11;
    @(negedge config_clk);
    in_data = 8'h22;
    @(negedge config_clk);
    abort = 1'b1;
    in_data = 8'h33;
    @(negedge config_clk);
    abort = 1'b0;
    in_valid = 1'b0;
    check("abort_pulse", {31'd0, aborted}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    check("abort_cfg_en", {31'd0, cfg_en}, 32'd0);
    @(negedge config_clk);
    check("abort_single", {31'd0, aborted}, 32'd0);
    v = '{data: 32'h01020304, gaps: 6'b00_00_00, restart: 3'd7, in_commit: 1'b0, with_abort: 1'b0};
    do_load(v);

    // asynchronous reset after three beats
    @(negedge config_clk);
    start = 1'b1;
    @(negedge config_clk);
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hAA + 8'(i);
      @(negedge config_clk);
    end
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("async_rst_cfg_data", cfg_data, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge config_clk);
    rst = 1'b0;
    @(negedge config_clk);
    check("rel_busy", {31'd0, busy}, 32'd0);
    check("rel_cfg_en", {31'd0, cfg_en}, 32'd0);
    repeat (3) @(negedge config_clk);
    check("rel_no_commit", {31'd0, busy}, 32'd0);
    v = '{data: 32'hDEADBEEF, gaps: 6'b00_00_00, restart: 3'd7, in_commit: 1'b0, with_abort: 1'b0};
    do_load(v);

    @(negedge config_clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
